// File: rtl/btc_pkg.sv
//============================================================================
// Module   : btc_pkg
// Brief    : Shared constants and state encoding for the Bitcoin
//            double-SHA-256 hash sequencer.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package btc_pkg;

    localparam int HDR_WORDS = 20;

    localparam logic [31:0] SHA256_IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] PAD_WORD = 32'h8000_0000;
    localparam logic [31:0] LEN_640  = 32'h0000_0280;
    localparam logic [31:0] LEN_256  = 32'h0000_0100;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P1_WAIT = 3'd1,
        P2_WAIT = 3'd2,
        P3_WAIT = 3'd3,
        DONE    = 3'd4
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/btc_hash_sequencer_if.sv
//============================================================================
// Module   : btc_hash_sequencer_if
// Brief    : Operand/result bus between the hash sequencer (master) and the
//            SHA-256 round engine (slave).
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

interface btc_hash_sequencer_if;

    logic        sha_start;
    logic [31:0] sha_w        [16];
    logic [31:0] sha_hash_in  [8];
    logic [31:0] sha_hash_out [8];
    logic        sha_hash_done;

    modport master (
        output sha_start,
        output sha_w,
        output sha_hash_in,
        input  sha_hash_out,
        input  sha_hash_done
    );

    modport slave (
        input  sha_start,
        input  sha_w,
        input  sha_hash_in,
        output sha_hash_out,
        output sha_hash_done
    );

endinterface

`default_nettype wire

// File: rtl/btc_hash_sequencer.sv
//============================================================================
// Module   : btc_hash_sequencer
// Brief    : Drives the SHA-256 engine through header block 1, header block 2
//            and the second-hash block; returns the double-SHA-256 digest.
//            Optional midstate reuse: define BTC_MIDSTATE_CACHE_EN.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module btc_hash_sequencer
    import btc_pkg::*;
#(
    parameter int NUM_OF_WORDS = HDR_WORDS
) (
    input  wire               clk,
    input  wire               reset,
    input  wire               start,
`ifdef BTC_MIDSTATE_CACHE_EN
    input  wire               reuse_mid,
`endif
    input  wire  [31:0]       header_w [NUM_OF_WORDS],
    input  wire  [31:0]       nonce,
    output logic              busy,
    output logic              done,
    output logic [31:0]       digest [8],
    btc_hash_sequencer_if.master sha
);

    seq_state_t  r_state;
    seq_state_t  w_state_nxt;

    logic        r_busy;
    logic        r_done;
    logic        r_sha_start;
    logic [31:0] r_digest   [8];
    logic [31:0] r_sha_w    [16];
    logic [31:0] r_sha_hin  [8];
    logic [31:0] r_hdr_tail [3];
    logic [31:0] r_nonce;

    logic        w_load;
    logic        w_snap;
    logic        w_finish;
    logic        w_skip_p1;
    logic [31:0] w_tail     [3];
    logic [31:0] w_nonce;
    logic [31:0] w_mid_src  [8];
    logic [31:0] w_blk_w    [16];
    logic [31:0] w_blk_hin  [8];

`ifdef BTC_MIDSTATE_CACHE_EN
    logic [31:0] r_mid [8];
    logic        r_cache_valid;

    assign w_skip_p1 = reuse_mid & r_cache_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mid         <= '{default: '0};
            r_cache_valid <= 1'b0;
        end else if (r_state == P1_WAIT && sha.sha_hash_done) begin
            r_mid         <= sha.sha_hash_out;
            r_cache_valid <= 1'b1;
        end
    end

    // A cached start launches P2 straight from IDLE, so the midstate comes
    // from the cache instead of the engine result bus.
    always_comb begin
        w_mid_src = sha.sha_hash_out;
        if (r_state == IDLE) begin
            w_mid_src = r_mid;
        end
    end
`else
    assign w_skip_p1 = 1'b0;

    always_comb begin
        w_mid_src = sha.sha_hash_out;
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_snap      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_snap      = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = w_skip_p1 ? P2_WAIT : P1_WAIT;
                end
            end
            P1_WAIT: begin
                if (sha.sha_hash_done) begin
                    w_load      = 1'b1;
                    w_state_nxt = P2_WAIT;
                end
            end
            P2_WAIT: begin
                if (sha.sha_hash_done) begin
                    w_load      = 1'b1;
                    w_state_nxt = P3_WAIT;
                end
            end
            P3_WAIT: begin
                if (sha.sha_hash_done) begin
                    w_finish    = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Header tail and nonce are live inputs only on the accepting cycle.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_tail[k] = (r_state == IDLE) ? header_w[16 + k] : r_hdr_tail[k];
        end
        w_nonce = (r_state == IDLE) ? nonce : r_nonce;
    end

    // Block builder: operands for the pass about to be launched.
    always_comb begin
        w_blk_w   = r_sha_w;
        w_blk_hin = r_sha_hin;
        case (w_state_nxt)
            P1_WAIT: begin
                for (int i = 0; i < 16; i++) begin
                    w_blk_w[i] = header_w[i];
                end
                w_blk_hin = SHA256_IV;
            end
            P2_WAIT: begin
                for (int i = 0; i < 16; i++) begin
                    w_blk_w[i] = '0;
                end
                for (int k = 0; k < 3; k++) begin
                    w_blk_w[k] = w_tail[k];
                end
                w_blk_w[3]  = w_nonce;
                w_blk_w[4]  = PAD_WORD;
                w_blk_w[15] = LEN_640;
                w_blk_hin   = w_mid_src;
            end
            P3_WAIT: begin
                for (int i = 0; i < 16; i++) begin
                    w_blk_w[i] = '0;
                end
                for (int i = 0; i < 8; i++) begin
                    w_blk_w[i] = sha.sha_hash_out[i];
                end
                w_blk_w[8]  = PAD_WORD;
                w_blk_w[15] = LEN_256;
                w_blk_hin   = SHA256_IV;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sha_start <= 1'b0;
            r_digest    <= '{default: '0};
            r_sha_w     <= '{default: '0};
            r_sha_hin   <= '{default: '0};
            r_hdr_tail  <= '{default: '0};
            r_nonce     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sha_start <= w_load;
            r_done      <= w_finish;
            // Operands change only when a new pass is launched.
            if (w_load) begin
                r_sha_w   <= w_blk_w;
                r_sha_hin <= w_blk_hin;
            end
            if (w_snap) begin
                r_hdr_tail <= w_tail;
                r_nonce    <= nonce;
                r_busy     <= 1'b1;
            end else if (r_state == DONE) begin
                r_busy <= 1'b0;
            end
            if (w_finish) begin
                r_digest <= sha.sha_hash_out;
            end
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign digest          = r_digest;
    assign sha.sha_start   = r_sha_start;
    assign sha.sha_w       = r_sha_w;
    assign sha.sha_hash_in = r_sha_hin;

endmodule

`default_nettype wire
